// File: rtl/rams_dp_dist_clr.sv
// Dual-port distributed RAM with per-byte write enables, optional registered read,
// and a clear engine that walks every word to INIT_VAL after reset or on request.
module rams_dp_dist_clr #(
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       ADDR_W   = 6,
  parameter int unsigned       READ_REG = 0,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   a,
  input  logic [ADDR_W-1:0]   dpra,
  input  logic [DATA_W-1:0]   di,
  input  logic                clr,
  output logic [DATA_W-1:0]   spo,
  output logic [DATA_W-1:0]   dpo,
  output logic                busy,
  output logic                coll
);

  localparam int unsigned Depth    = 2 ** ADDR_W;
  localparam int unsigned NumBytes = DATA_W / 8;

  typedef enum logic [0:0] {StClear, StIdle} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              coll_q, coll_d;

  // Storage has no reset; the clear engine defines its contents.
  logic [DATA_W-1:0] mem_q [Depth];

  logic              busy_int;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] spo_d, dpo_d;

  assign busy_int = (state_q == StClear);

  // Clear-engine sequencing and collision detection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StClear: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == {ADDR_W{1'b1}}) state_d = StIdle;
      end
      StIdle: begin
        // A write arriving with clr still lands this edge; the walk then overwrites it.
        if (clr) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      default: state_d = StClear;
    endcase
    coll_d = we && !busy_int && (a == dpra);
  end

  // Control state; reset (even mid-clear) restarts the walk from address 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StClear;
      cnt_q   <= '0;
      coll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      coll_q  <= coll_d;
    end
  end

  // Single write port shared by the clear walk and byte-masked user writes.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = a;
    wr_data = mem_q[a];
    if (busy_int) begin
      wr_en   = 1'b1;
      wr_addr = cnt_q;
      wr_data = INIT_VAL;
    end else if (we) begin
      wr_en = 1'b1;
      for (int i = 0; i < NumBytes; i++) begin
        if (be[i]) wr_data[8*i +: 8] = di[8*i +: 8];
      end
    end
  end

  // Memory array write.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // Reads are masked to INIT_VAL while the clear engine owns the array.
  always_comb begin
    spo_d = busy_int ? INIT_VAL : mem_q[a];
    dpo_d = busy_int ? INIT_VAL : mem_q[dpra];
  end

  if (READ_REG != 0) begin : g_read_reg
    logic [DATA_W-1:0] spo_q, dpo_q;

    // Registered read sees pre-write contents, giving read-first collisions.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        spo_q <= INIT_VAL;
        dpo_q <= INIT_VAL;
      end else begin
        spo_q <= spo_d;
        dpo_q <= dpo_d;
      end
    end

    assign spo = spo_q;
    assign dpo = dpo_q;
  end else begin : g_read_async
    assign spo = spo_d;
    assign dpo = dpo_d;
  end

  assign busy = busy_int;
  assign coll = coll_q;

endmodule
